row_col_allocator: RTL and testbench
====================================

Name: row_col_allocator

Overview:
- Parametrised successor to the single-table ID-to-slot mapper in the ROB front end.
- Maps each original AXI ID to a row: one row per in-flight ID.
- Issues a per-row column (sequence slot), producing unique_id = {row, col}.
- Adds an allocate handshake, an in-order per-row free path, a full/stall policy and error reporting.
- Sits between the AR/AW request path (allocate) and the response retire path (free).

Parameters:
- ID_WIDTH, 4, original AXI ID width.
- NUM_ROWS, 16, number of distinct IDs that may be outstanding at once (>=2).
- NUM_COLS, 16, maximum outstanding transactions per row (>=2, power of two).
- ROW_W (localparam), $clog2(NUM_ROWS).
- COL_W (localparam), $clog2(NUM_COLS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  allocation request.
- alloc_id  in  ID_WIDTH  original ID of the request.
- alloc_ready  out  1  combinational; request is accepted when alloc_valid & alloc_ready (fire).
- uid_valid  out  1  registered one-cycle pulse, the cycle after fire.
- unique_id  out  ROW_W+COL_W  {row, col} of the last grant; held between grants.
- free_valid  in  1  retire the oldest entry of a row.
- free_row  in  ROW_W  row to retire.
- free_col  in  COL_W  column being retired; checked against the row's read pointer.
- free_err  out  1  registered one-cycle pulse on an illegal free.
- row_bound  out  NUM_ROWS  per-row bound flag, registered.
- rows_full  out  1  all rows bound, registered.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - Every row: bound=0, id=0, wr_ptr=0, rd_ptr=0, cnt=0.
  - uid_valid=0, unique_id=0, free_err=0, row_bound=0, rows_full=0.
  - Reset asserted mid-operation discards all outstanding state; no pulse is emitted in the cycle after reset deasserts.
- Per-row state:
  - bound, id[ID_WIDTH], wr_ptr[COL_W], rd_ptr[COL_W], cnt[COL_W+1].
- Lookup (combinational, on pre-update state):
  - hit = some row with bound & id==alloc_id. At most one row can match (invariant, asserted).
  - free_idx = lowest-index row with bound==0.
- alloc_ready:
  - hit: ready = (cnt of hit row < NUM_COLS).
  - miss: ready = any unbound row.
  - Independent of alloc_valid. Does not see same-cycle frees (no bypass).
- On fire, hit row r:
  - Grant {r, wr_ptr[r]}.
  - wr_ptr[r] increments modulo NUM_COLS (wraps from NUM_COLS-1 to 0).
  - cnt[r] increments.
- On fire, miss:
  - Row f = free_idx becomes bound with id=alloc_id.
  - Grant {f, wr_ptr[f]}; then wr_ptr[f]++ and cnt[f]=1.
  - Pointers are not reset on bind; they continue from their last values.
- Latency: uid_valid pulses and unique_id updates exactly 1 cycle after fire. Back-to-back fires give back-to-back pulses.
- Free path:
  - Legal when row bound & cnt>0 & free_col==rd_ptr. Effect: rd_ptr++ (mod NUM_COLS), cnt--.
  - If cnt reaches 0 and there is no same-row fire this cycle, bound is cleared. id is kept but ignored.
  - Illegal free: state unchanged; free_err pulses the next cycle.
- Simultaneous fire and free:
  - Same row: both apply, cnt net unchanged, row stays bound even if the free would have emptied it.
  - Different rows: independent.
  - A row released this cycle is not allocatable until the next cycle.
- row_bound and rows_full reflect post-update state, registered.

Decomposition:
- Package rob_pkg holds:
  - Typedef row_state_t (bound, id, wr_ptr, rd_ptr, cnt), widths derived from the package parameters.
  - Helper constants for ROW_W and COL_W.
- Sub-module rob_prio_enc(N): lowest-set-bit priority encoder with found flag. Used for free_idx; it may also encode the hit vector.
- Simulation-only assertions:
  - ID uniqueness across bound rows.
  - No fire when alloc_ready=0.
  - cnt <= NUM_COLS.

Test Plan (NUM_ROWS=4, NUM_COLS=4):
- Reset, then alloc id=5 -> ready=1; next cycle uid_valid=1, unique_id={0,0}; row_bound=0001.
- Alloc id=5 three more times, back to back -> unique_id {0,1},{0,2},{0,3} on consecutive cycles; 5th alloc id=5 -> alloc_ready=0.
- Alloc ids 1,2,3 -> rows 1,2,3 bound, rows_full=1; alloc id=9 -> ready=0; free row1 col0 -> row_bound=1101 next cycle; alloc id=9 -> {1,1}.
- Row0 full (cnt=4): same-cycle alloc id=5 and free row0 col0 -> ready stays 0, no grant; next cycle ready=1 and a grant yields {0,0} (wr_ptr wrapped).
- Free row2 with free_col=3 while rd_ptr=0 -> free_err pulse, cnt unchanged; free of an unbound row -> free_err pulse.
- Assert rst mid-traffic with 3 rows bound -> all outputs 0 immediately; after release, alloc id=5 -> {0,0}.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and row-state layout for the ROB ID-to-{row,col} allocator.
package rob_pkg;

    localparam int DEF_ID_WIDTH = 4;
    localparam int DEF_NUM_ROWS = 16;
    localparam int DEF_NUM_COLS = 16;
    localparam int DEF_ROW_W    = $clog2(DEF_NUM_ROWS);
    localparam int DEF_COL_W    = $clog2(DEF_NUM_COLS);

    // cnt is one bit wider than the pointers so a completely full row is representable.
    typedef struct packed {
        logic                    bound;
        logic [DEF_ID_WIDTH-1:0] id;
        logic [DEF_COL_W-1:0]    wr_ptr;
        logic [DEF_COL_W-1:0]    rd_ptr;
        logic [DEF_COL_W:0]      cnt;
    } row_state_t;

endpackage

// File: rtl/rob_prio_enc.sv
// Lowest-set-bit priority encoder; idx is 0 when nothing is set.
module rob_prio_enc #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_col_allocator.sv
// Maps each in-flight AXI ID to a row and hands out per-row sequence columns,
// producing unique_id = {row, col}; entries retire in order per row.
module row_col_allocator
    import rob_pkg::*;
#(
    parameter int ID_WIDTH = DEF_ID_WIDTH,
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int NUM_COLS = DEF_NUM_COLS,
    localparam int ROW_W = $clog2(NUM_ROWS),
    localparam int COL_W = $clog2(NUM_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    input  logic [ID_WIDTH-1:0]    alloc_id,
    output logic                   alloc_ready,
    output logic                   uid_valid,
    output logic [ROW_W+COL_W-1:0] unique_id,
    input  logic                   free_valid,
    input  logic [ROW_W-1:0]       free_row,
    input  logic [COL_W-1:0]       free_col,
    output logic                   free_err,
    output logic [NUM_ROWS-1:0]    row_bound,
    output logic                   rows_full
);

    typedef struct packed {
        logic                bound;
        logic [ID_WIDTH-1:0] id;
        logic [COL_W-1:0]    wr_ptr;
        logic [COL_W-1:0]    rd_ptr;
        logic [COL_W:0]      cnt;
    } row_t;

    localparam logic [COL_W:0] CNT_FULL  = (COL_W + 1)'(NUM_COLS);
    localparam logic [COL_W:0] CNT_ONE   = (COL_W + 1)'(1);
    localparam bit             ROWS_POW2 = (NUM_ROWS == (1 << ROW_W));

    row_t                rows_q [NUM_ROWS];
    row_t                rows_d [NUM_ROWS];
    logic [NUM_ROWS-1:0] hit_vec;
    logic [NUM_ROWS-1:0] unbound_vec;
    logic [NUM_ROWS-1:0] fire_row;
    logic [NUM_ROWS-1:0] free_sel;
    logic [NUM_ROWS-1:0] row_bound_d;
    logic [ROW_W-1:0]    hit_idx;
    logic [ROW_W-1:0]    free_idx;
    logic [ROW_W-1:0]    tgt_row;
    logic                hit_found;
    logic                free_found;
    logic                fire;
    logic                row_in_range;
    logic                free_legal;

    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            hit_vec[i]     = rows_q[i].bound && (rows_q[i].id == alloc_id);
            unbound_vec[i] = !rows_q[i].bound;
        end
    end

    rob_prio_enc #(.N(NUM_ROWS)) u_hit_enc (
        .req   (hit_vec),
        .idx   (hit_idx),
        .found (hit_found)
    );

    rob_prio_enc #(.N(NUM_ROWS)) u_free_enc (
        .req   (unbound_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    // Handshake: a request fires when alloc_valid && alloc_ready; ready depends only on
    // registered state (never on alloc_valid or a same-cycle free) and valid may not wait on it.
    assign alloc_ready  = hit_found ? (rows_q[hit_idx].cnt < CNT_FULL) : free_found;
    assign fire         = alloc_valid && alloc_ready;
    assign tgt_row      = hit_found ? hit_idx : free_idx;
    assign row_in_range = ROWS_POW2 || (int'(free_row) < NUM_ROWS);

    always_comb begin
        free_legal = 1'b0;
        if (free_valid && row_in_range) begin
            free_legal = rows_q[free_row].bound && (rows_q[free_row].cnt != '0)
                         && (rows_q[free_row].rd_ptr == free_col);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            fire_row[i] = fire && (tgt_row == ROW_W'(i));
            free_sel[i] = free_legal && (free_row == ROW_W'(i));
        end
    end

    // A same-row fire keeps the row bound even when the free would have drained it.
    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            rows_d[i] = rows_q[i];
            if (fire_row[i]) begin
                rows_d[i].bound  = 1'b1;
                rows_d[i].id     = alloc_id;
                rows_d[i].wr_ptr = rows_q[i].wr_ptr + COL_W'(1);
            end
            if (free_sel[i]) begin
                rows_d[i].rd_ptr = rows_q[i].rd_ptr + COL_W'(1);
            end
            if (fire_row[i] && !free_sel[i]) begin
                rows_d[i].cnt = rows_q[i].cnt + CNT_ONE;
            end else if (free_sel[i] && !fire_row[i]) begin
                rows_d[i].cnt = rows_q[i].cnt - CNT_ONE;
                if (rows_q[i].cnt == CNT_ONE) begin
                    rows_d[i].bound = 1'b0;
                end
            end
            row_bound_d[i] = rows_d[i].bound;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows_q[i] <= '0;
            end
            uid_valid <= 1'b0;
            unique_id <= '0;
            free_err  <= 1'b0;
            row_bound <= '0;
            rows_full <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows_q[i] <= rows_d[i];
            end
            uid_valid <= fire;
            if (fire) begin
                unique_id <= {tgt_row, rows_q[tgt_row].wr_ptr};
            end
            free_err  <= free_valid && !free_legal;
            row_bound <= row_bound_d;
            rows_full <= &row_bound_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(hit_vec))
                else $error("alloc_id matches more than one bound row");
            assert (!(fire && !alloc_ready))
                else $error("grant issued while alloc_ready low");
            for (int i = 0; i < NUM_ROWS; i++) begin
                assert (rows_q[i].cnt <= CNT_FULL)
                    else $error("row %0d count overflow", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_row_col_allocator.sv
// Bench for row_col_allocator: directed table, reset sequences and a random run
// checked against a queue-based model of the rows.
module tb_row_col_allocator;

    localparam int ID_WIDTH = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;

    logic                   clk;
    logic                   rst;
    logic                   alloc_valid;
    logic [ID_WIDTH-1:0]    alloc_id;
    logic                   alloc_ready;
    logic                   uid_valid;
    logic [ROW_W+COL_W-1:0] unique_id;
    logic                   free_valid;
    logic [ROW_W-1:0]       free_row;
    logic [COL_W-1:0]       free_col;
    logic                   free_err;
    logic [NUM_ROWS-1:0]    row_bound;
    logic                   rows_full;

    row_col_allocator #(
        .ID_WIDTH (ID_WIDTH),
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_id    (alloc_id),
        .alloc_ready (alloc_ready),
        .uid_valid   (uid_valid),
        .unique_id   (unique_id),
        .free_valid  (free_valid),
        .free_row    (free_row),
        .free_col    (free_col),
        .free_err    (free_err),
        .row_bound   (row_bound),
        .rows_full   (rows_full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;
    int last_ready;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // reference model: each row is a FIFO of outstanding columns
    bit m_bound [NUM_ROWS];
    int m_id    [NUM_ROWS];
    int m_wr    [NUM_ROWS];
    int m_q     [NUM_ROWS][$];
    int e_uidv, e_uid, e_ferr, e_rb, e_full;

    function automatic int m_hit(input int id);
        for (int r = 0; r < NUM_ROWS; r++)
            if (m_bound[r] && m_id[r] == id) return r;
        return -1;
    endfunction

    function automatic int m_free();
        for (int r = 0; r < NUM_ROWS; r++)
            if (!m_bound[r]) return r;
        return -1;
    endfunction

    function automatic int m_ready(input int id);
        int h;
        h = m_hit(id);
        if (h >= 0) return (m_q[h].size() < NUM_COLS) ? 1 : 0;
        return (m_free() >= 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_ROWS; r++) begin
            m_bound[r] = 0;
            m_id[r]    = 0;
            m_wr[r]    = 0;
            m_q[r].delete();
        end
        e_uidv = 0; e_uid = 0; e_ferr = 0; e_rb = 0; e_full = 0;
    endtask

    task automatic model_step(input int v, input int id, input int fv, input int frow, input int fcol);
        int h, tgt, col;
        bit fire, legal;
        h     = m_hit(id);
        tgt   = (h >= 0) ? h : m_free();
        fire  = (v != 0) && (m_ready(id) != 0);
        legal = (fv != 0) && m_bound[frow] && (m_q[frow].size() > 0) && (m_q[frow][0] == fcol);
        if (legal) void'(m_q[frow].pop_front());
        if (fire) begin
            col          = m_wr[tgt];
            m_bound[tgt] = 1;
            m_id[tgt]    = id;
            m_q[tgt].push_back(col);
            m_wr[tgt]    = (col + 1) % NUM_COLS;
            e_uid        = tgt * NUM_COLS + col;
        end
        if (legal && m_q[frow].size() == 0) m_bound[frow] = 0;
        e_uidv = fire ? 1 : 0;
        e_ferr = ((fv != 0) && !legal) ? 1 : 0;
        e_rb   = 0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (m_bound[r]) e_rb = e_rb | (1 << r);
        e_full = (e_rb == (1 << NUM_ROWS) - 1) ? 1 : 0;
    endtask

    // driver: called at posedge+1, leaves the bench at the next posedge+1
    task automatic do_cycle(input int v, input int id, input int fv, input int frow, input int fcol);
        alloc_valid = v[0];
        alloc_id    = ID_WIDTH'(id);
        free_valid  = fv[0];
        free_row    = ROW_W'(frow);
        free_col    = COL_W'(fcol);
        #1;
        last_ready = int'(alloc_ready);
        check("alloc_ready", last_ready, m_ready(id));
        model_step(v, id, fv, frow, fcol);
        @(posedge clk);
        #1;
        check("uid_valid", int'(uid_valid), e_uidv);
        check("unique_id", int'(unique_id), e_uid);
        check("free_err",  int'(free_err),  e_ferr);
        check("row_bound", int'(row_bound), e_rb);
        check("rows_full", int'(rows_full), e_full);
    endtask

    task automatic drive_idle();
        alloc_valid = 1'b0;
        alloc_id    = '0;
        free_valid  = 1'b0;
        free_row    = '0;
        free_col    = '0;
    endtask

    typedef struct {
        int v, id, fv, frow, fcol;
        int rdy, uidv, uid, ferr, rb, full;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int v, id, fv, frow, fcol;

        vecs[0]  = '{1, 5, 0, 0, 0,  1, 1,  0, 0,  1, 0};
        vecs[1]  = '{1, 5, 0, 0, 0,  1, 1,  1, 0,  1, 0};
        vecs[2]  = '{1, 5, 0, 0, 0,  1, 1,  2, 0,  1, 0};
        vecs[3]  = '{1, 5, 0, 0, 0,  1, 1,  3, 0,  1, 0};
        vecs[4]  = '{1, 5, 0, 0, 0,  0, 0,  3, 0,  1, 0};
        vecs[5]  = '{1, 1, 0, 0, 0,  1, 1,  4, 0,  3, 0};
        vecs[6]  = '{1, 2, 0, 0, 0,  1, 1,  8, 0,  7, 0};
        vecs[7]  = '{1, 3, 0, 0, 0,  1, 1, 12, 0, 15, 1};
        vecs[8]  = '{1, 9, 0, 0, 0,  0, 0, 12, 0, 15, 1};
        vecs[9]  = '{0, 0, 1, 1, 0,  0, 0, 12, 0, 13, 0};
        vecs[10] = '{1, 9, 0, 0, 0,  1, 1,  5, 0, 15, 1};
        vecs[11] = '{1, 5, 1, 0, 0,  0, 0,  5, 0, 15, 1};
        vecs[12] = '{1, 5, 0, 0, 0,  1, 1,  0, 0, 15, 1};
        vecs[13] = '{0, 0, 1, 2, 3,  0, 0,  0, 1, 15, 1};
        vecs[14] = '{0, 0, 1, 2, 0,  0, 0,  0, 0, 11, 0};
        vecs[15] = '{0, 0, 1, 2, 1,  1, 0,  0, 1, 11, 0};
        vecs[16] = '{1, 9, 1, 1, 1,  1, 1,  6, 0, 11, 0};
        vecs[17] = '{0, 0, 1, 1, 2,  1, 0,  6, 0,  9, 0};

        // power-on reset
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_uid_valid", int'(uid_valid), 0);
        check("rst_unique_id", int'(unique_id), 0);
        check("rst_free_err",  int'(free_err),  0);
        check("rst_row_bound", int'(row_bound), 0);
        check("rst_rows_full", int'(rows_full), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_uid_valid", int'(uid_valid), 0);

        // directed table
        for (int i = 0; i < 18; i++) begin
            do_cycle(vecs[i].v, vecs[i].id, vecs[i].fv, vecs[i].frow, vecs[i].fcol);
            check($sformatf("tbl%0d_ready", i), last_ready,          vecs[i].rdy);
            check($sformatf("tbl%0d_uidv", i),  int'(uid_valid),     vecs[i].uidv);
            check($sformatf("tbl%0d_uid", i),   int'(unique_id),     vecs[i].uid);
            check($sformatf("tbl%0d_ferr", i),  int'(free_err),      vecs[i].ferr);
            check($sformatf("tbl%0d_rb", i),    int'(row_bound),     vecs[i].rb);
            check($sformatf("tbl%0d_full", i),  int'(rows_full),     vecs[i].full);
        end

        // mid-traffic reset with three rows bound and a pulse in flight
        do_cycle(1, 7, 0, 0, 0);
        check("pre_rst_rb", int'(row_bound), 11);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_uid_valid", int'(uid_valid), 0);
        check("mid_rst_unique_id", int'(unique_id), 0);
        check("mid_rst_free_err",  int'(free_err),  0);
        check("mid_rst_row_bound", int'(row_bound), 0);
        check("mid_rst_rows_full", int'(rows_full), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 5, 0, 0, 0);
        check("post_rst_grant", int'(unique_id), 0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 99) < 60) ? 1 : 0;
            id   = $urandom_range(0, 6);
            fv   = ($urandom_range(0, 99) < 45) ? 1 : 0;
            frow = $urandom_range(0, NUM_ROWS - 1);
            if ($urandom_range(0, 9) < 8 && m_bound[frow] && m_q[frow].size() > 0)
                fcol = m_q[frow][0];
            else
                fcol = $urandom_range(0, NUM_COLS - 1);
            do_cycle(v, id, fv, frow, fcol);
        end

        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
